// File: rtl/gpio_in_pkg.sv
// Shared definitions for the AXI-Lite GPIO input bank: register offsets,
// response codes, bus FSM states and the byte-strobe expansion helper.
package gpio_in_pkg;

  localparam logic [11:0] GPIO_IN_DATA_OFF       = 12'h000;
  localparam logic [11:0] GPIO_IN_IRQ_EN_OFF     = 12'h004;
  localparam logic [11:0] GPIO_IN_IRQ_STATUS_OFF = 12'h008;
  localparam logic [11:0] GPIO_IN_EDGE_SEL_OFF   = 12'h00C;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } axil_resp_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] mask;
    for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{strb[b]}};
    return mask;
  endfunction

endpackage

// File: rtl/gpio_debouncer.sv
// Two-flop synchroniser followed by a per-bit debounce counter; a bit is
// accepted only after it has differed from the stable value for DEBOUNCE_CYCLES cycles.
module gpio_debouncer #(
  parameter int NUM_GPIO        = 16,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_GPIO-1:0] in_i,
  output logic [NUM_GPIO-1:0] stable_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_GPIO-1:0] sync_p0, sync_p1, stable_p2;
  logic [CNT_W-1:0]    cnt_q [NUM_GPIO];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_p0   <= '0;
      sync_p1   <= '0;
      stable_p2 <= '0;
      for (int i = 0; i < NUM_GPIO; i++) cnt_q[i] <= '0;
    end else begin
      // p0/p1: metastability guard on the asynchronous board inputs
      sync_p0 <= in_i;
      sync_p1 <= sync_p0;
      // p2: debounce, any return to the stable level restarts the count
      for (int i = 0; i < NUM_GPIO; i++) begin
        if (sync_p1[i] == stable_p2[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          stable_p2[i] <= sync_p1[i];
          cnt_q[i]     <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign stable_o = stable_p2;

endmodule

// File: rtl/axilite_gpio_in.sv
// AXI-Lite GPIO input bank: debounced DATA register plus, when GPIO_IN_IRQ_EN
// is defined, edge detection with IRQ_EN / IRQ_STATUS (W1C) / EDGE_SEL and a level interrupt.
module axilite_gpio_in
  import gpio_in_pkg::*;
#(
  parameter int NUM_GPIO        = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int ADDR_WIDTH      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_GPIO-1:0]   gpio_in_i,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [31:0]           s_axil_wdata,
  input  logic [3:0]            s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [31:0]           s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic                  int_o
);

  logic [NUM_GPIO-1:0] stable;

  gpio_debouncer #(
    .NUM_GPIO        (NUM_GPIO),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .in_i     (gpio_in_i),
    .stable_o (stable)
  );

  logic [11:0] wr_addr, rd_addr;
  assign wr_addr = {s_axil_awaddr[11:2], 2'b00};
  assign rd_addr = {s_axil_araddr[11:2], 2'b00};

  // Upper address bits and unused data/strobe bits are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{s_axil_awaddr, s_axil_araddr, s_axil_wdata, s_axil_wstrb};

  wr_state_t  wr_state, wr_state_nxt;
  rd_state_t  rd_state, rd_state_nxt;
  logic       wr_fire, rd_fire;
  axil_resp_t wr_resp_nxt, rd_resp_nxt, bresp_q, rresp_q;
  logic [31:0] rd_data_nxt, rdata_q;

  always_comb begin
    wr_state_nxt   = wr_state;
    s_axil_awready = 1'b0;
    s_axil_wready  = 1'b0;
    s_axil_bvalid  = 1'b0;
    wr_fire        = 1'b0;
    case (wr_state)
      W_IDLE: begin
        if (s_axil_awvalid && s_axil_wvalid && !rst_i) begin
          s_axil_awready = 1'b1;
          s_axil_wready  = 1'b1;
          wr_fire        = 1'b1;
          wr_state_nxt   = W_RESP;
        end
      end
      W_RESP: begin
        s_axil_bvalid = 1'b1;
        if (s_axil_bready) wr_state_nxt = W_IDLE;
      end
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    wr_resp_nxt = OKAY;
    case (wr_addr)
      GPIO_IN_DATA_OFF, GPIO_IN_IRQ_EN_OFF,
      GPIO_IN_IRQ_STATUS_OFF, GPIO_IN_EDGE_SEL_OFF: wr_resp_nxt = OKAY;
      default:                                      wr_resp_nxt = SLVERR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_state <= W_IDLE;
      bresp_q  <= OKAY;
    end else begin
      wr_state <= wr_state_nxt;
      if (wr_fire) bresp_q <= wr_resp_nxt;
    end
  end

  assign s_axil_bresp = bresp_q;

  always_comb begin
    rd_state_nxt   = rd_state;
    s_axil_arready = 1'b0;
    s_axil_rvalid  = 1'b0;
    rd_fire        = 1'b0;
    case (rd_state)
      R_IDLE: begin
        s_axil_arready = !rst_i;
        if (s_axil_arvalid && !rst_i) begin
          rd_fire      = 1'b1;
          rd_state_nxt = R_DATA;
        end
      end
      R_DATA: begin
        s_axil_rvalid = 1'b1;
        if (s_axil_rready) rd_state_nxt = R_IDLE;
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

`ifdef GPIO_IN_IRQ_EN
  logic [NUM_GPIO-1:0] irq_en_q, irq_status_q, edge_sel_q, stable_prev_q;
  logic [NUM_GPIO-1:0] wr_bits, wr_mask, edge_hit, status_clr;
  logic [31:0]         strb_mask;
  logic                int_q;

  assign strb_mask  = strb_to_mask(s_axil_wstrb);
  assign wr_bits    = s_axil_wdata[NUM_GPIO-1:0];
  assign wr_mask    = strb_mask[NUM_GPIO-1:0];
  assign edge_hit   = (edge_sel_q & stable & ~stable_prev_q) |
                      (~edge_sel_q & ~stable & stable_prev_q);
  assign status_clr = (wr_fire && wr_addr == GPIO_IN_IRQ_STATUS_OFF) ? (wr_bits & wr_mask) : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_en_q      <= '0;
      irq_status_q  <= '0;
      edge_sel_q    <= '0;
      stable_prev_q <= '0;
      int_q         <= 1'b0;
    end else begin
      stable_prev_q <= stable;
      // a fresh edge overrides a simultaneous W1C of the same bit
      irq_status_q  <= (irq_status_q & ~status_clr) | edge_hit;
      int_q         <= |(irq_status_q & irq_en_q);
      if (wr_fire && wr_addr == GPIO_IN_IRQ_EN_OFF)
        irq_en_q <= (irq_en_q & ~wr_mask) | (wr_bits & wr_mask);
      if (wr_fire && wr_addr == GPIO_IN_EDGE_SEL_OFF)
        edge_sel_q <= (edge_sel_q & ~wr_mask) | (wr_bits & wr_mask);
    end
  end

  assign int_o = int_q;
`else
  assign int_o = 1'b0;
`endif

  always_comb begin
    rd_data_nxt = '0;
    rd_resp_nxt = OKAY;
    case (rd_addr)
      GPIO_IN_DATA_OFF:       rd_data_nxt = 32'(stable);
`ifdef GPIO_IN_IRQ_EN
      GPIO_IN_IRQ_EN_OFF:     rd_data_nxt = 32'(irq_en_q);
      GPIO_IN_IRQ_STATUS_OFF: rd_data_nxt = 32'(irq_status_q);
      GPIO_IN_EDGE_SEL_OFF:   rd_data_nxt = 32'(edge_sel_q);
`else
      GPIO_IN_IRQ_EN_OFF, GPIO_IN_IRQ_STATUS_OFF,
      GPIO_IN_EDGE_SEL_OFF:   rd_data_nxt = '0;
`endif
      default:                rd_resp_nxt = SLVERR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_state <= R_IDLE;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
    end else begin
      rd_state <= rd_state_nxt;
      if (rd_fire) begin
        rdata_q <= rd_data_nxt;
        rresp_q <= rd_resp_nxt;
      end
    end
  end

  assign s_axil_rdata = rdata_q;
  assign s_axil_rresp = rresp_q;

endmodule

// File: tb/tb_axilite_gpio_in.sv
// Directed plus randomized bench for axilite_gpio_in (DEBOUNCE_CYCLES = 8);
// IRQ checks follow GPIO_IN_IRQ_EN, otherwise the tied-off behaviour is checked.
module tb_axilite_gpio_in;

  localparam int NG  = 16;
  localparam int DEB = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [NG-1:0] gpio_in = '0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid, int_o;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int n_checks = 0;
  int n_fail   = 0;

  axilite_gpio_in #(
    .NUM_GPIO        (NG),
    .DEBOUNCE_CYCLES (DEB),
    .ADDR_WIDTH      (32)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .gpio_in_i      (gpio_in),
    .s_axil_awaddr  (awaddr),
    .s_axil_awvalid (awvalid),
    .s_axil_awready (awready),
    .s_axil_wdata   (wdata),
    .s_axil_wstrb   (wstrb),
    .s_axil_wvalid  (wvalid),
    .s_axil_wready  (wready),
    .s_axil_bresp   (bresp),
    .s_axil_bvalid  (bvalid),
    .s_axil_bready  (bready),
    .s_axil_araddr  (araddr),
    .s_axil_arvalid (arvalid),
    .s_axil_arready (arready),
    .s_axil_rdata   (rdata),
    .s_axil_rresp   (rresp),
    .s_axil_rvalid  (rvalid),
    .s_axil_rready  (rready),
    .int_o          (int_o)
  );

  always #5 clk = ~clk;

  // Reference: a bit takes a new level once the raw input has sat at that
  // level for DEB consecutive samples, seen two cycles later through the synchroniser.
  logic [NG-1:0] run_val, mdl_now, mdl_d1, mdl_d2;
  int            run_len [NG];

  always @(posedge clk) begin
    if (rst) begin
      run_val = '0;
      mdl_now = '0;
      mdl_d1  = '0;
      mdl_d2  = '0;
      for (int b = 0; b < NG; b++) run_len[b] = 0;
    end else begin
      mdl_d2 = mdl_d1;
      mdl_d1 = mdl_now;
      for (int b = 0; b < NG; b++) begin
        if (gpio_in[b] == run_val[b]) begin
          if (run_len[b] < DEB) run_len[b]++;
        end else begin
          run_val[b] = gpio_in[b];
          run_len[b] = 1;
        end
        if (run_len[b] >= DEB) mdl_now[b] = run_val[b];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output logic ok);
    int n;
    ok = 1'b0;
    resp = 2'b11;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 20) begin tick(); n++; end
    if (awready && wready) begin
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      n = 0;
      while (!bvalid && n < 20) begin tick(); n++; end
      if (bvalid) begin
        resp = bresp;
        ok = 1'b1;
        tick();
      end
    end
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output logic ok);
    int n;
    ok = 1'b0;
    data = 32'hDEAD_BEEF;
    resp = 2'b11;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 20) begin tick(); n++; end
    if (arready) begin
      tick();
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 20) begin tick(); n++; end
      if (rvalid) begin
        data = rdata;
        resp = rresp;
        ok = 1'b1;
        tick();
      end
    end
    arvalid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic        ok;
    logic [NG-1:0] v;
    int          hold;

    // 1. Reset
    repeat (3) tick();
    chk("rst_arready", arready, 0);
    chk("rst_awready", awready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_int", int_o, 0);
    rst = 1'b0;
    tick();
    axi_read(32'h0, d, r, ok);
    chk("rst_rd_ok", ok, 1);
    chk("rst_data", d, 32'h0);
    chk("rst_data_resp", r, 2'b00);
    chk("rst_int_after", int_o, 0);

    // 2. Debounce latency
    gpio_in = 16'h00A5;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("deb_model", dut.stable, mdl_d2);
      if (i == 9)  chk("deb_lat9", dut.stable, 32'h0);
      if (i == 10) chk("deb_lat10", dut.stable, 32'hA5);
    end
    axi_read(32'h0, d, r, ok);
    chk("data_a5", d, 32'h0000_00A5);

    // 3. Glitch of DEB-1 cycles on bit 3
    gpio_in = 16'h00AD;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("glitch_bit3", dut.stable[3], 0);
    end
    gpio_in = 16'h00A5;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("glitch_bit3_after", dut.stable[3], 0);
    end
    axi_read(32'h0, d, r, ok);
    chk("glitch_data", d, 32'h0000_00A5);

    // 5. Unmapped offsets, write to DATA, backpressure
    axi_read(32'h20, d, r, ok);
    chk("unmapped_rd_resp", r, 2'b10);
    chk("unmapped_rd_data", d, 32'h0);
    axi_write(32'h20, 32'hFFFF, 4'hF, r, ok);
    chk("unmapped_wr_resp", r, 2'b10);
    axi_write(32'h00, 32'hFFFF, 4'hF, r, ok);
    chk("data_wr_resp", r, 2'b00);
    axi_read(32'h0, d, r, ok);
    chk("data_wr_noeffect", d, 32'h0000_00A5);

    awaddr = 32'h0; wdata = 32'h1234; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_bvalid", bvalid, 1);
      chk("bp_awready", awready, 0);
      tick();
    end
    chk("bp_bresp", bresp, 2'b00);
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    tick();
    chk("bp_bvalid_done", bvalid, 0);

    // Reset while a read response is pending
    araddr = 32'h0; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    chk("mid_rvalid", rvalid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_rvalid", rvalid, 0);
    rready = 1'b1;
    tick();

`ifdef GPIO_IN_IRQ_EN
    // 4. Rising-edge interrupt on bit 0
    gpio_in = '0;
    repeat (14) tick();
    axi_write(32'h08, 32'hFFFF, 4'hF, r, ok);
    axi_read(32'h08, d, r, ok);
    chk("irq_status_cleared", d, 32'h0);
    axi_write(32'h0C, 32'hFFFF, 4'h1, r, ok);
    axi_read(32'h0C, d, r, ok);
    chk("edge_sel_strb", d, 32'h00FF);
    axi_write(32'h0C, 32'h1, 4'hF, r, ok);
    axi_write(32'h04, 32'h1, 4'hF, r, ok);
    chk("irq_en_resp", r, 2'b00);
    gpio_in = 16'h0001;
    for (int i = 1; i <= 13; i++) begin
      tick();
      if (i == 10) chk("irq_stable0", dut.stable[0], 1);
      if (i == 11) chk("irq_int_before", int_o, 0);
      if (i == 12) chk("irq_int_rise", int_o, 1);
    end
    axi_read(32'h08, d, r, ok);
    chk("irq_status_set", d, 32'h1);
    axi_write(32'h08, 32'h1, 4'hF, r, ok);
    chk("irq_w1c_resp", r, 2'b00);
    chk("irq_int_fall", int_o, 0);
    axi_read(32'h08, d, r, ok);
    chk("irq_status_w1c", d, 32'h0);
`else
    // 6. IRQ feature absent
    axi_write(32'h04, 32'hFFFF, 4'hF, r, ok);
    chk("noirq_wr_resp", r, 2'b00);
    chk("noirq_wr_ok", ok, 1);
    axi_read(32'h04, d, r, ok);
    chk("noirq_rd_data", d, 32'h0);
    chk("noirq_rd_resp", r, 2'b00);
`endif

    // Randomized input segments against the reference
    for (int seg = 0; seg < 40; seg++) begin
      v = NG'($urandom);
      hold = $urandom_range(1, 14);
      gpio_in = v;
      for (int i = 0; i < hold; i++) begin
        tick();
        chk("rand_stable", dut.stable, mdl_d2);
`ifndef GPIO_IN_IRQ_EN
        chk("rand_int_tied", int_o, 0);
`endif
      end
    end
    repeat (DEB + 4) tick();
    axi_read(32'h0, d, r, ok);
    chk("rand_final_data", d, 32'(mdl_d2));
    chk("rand_final_resp", r, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
